// File: rtl/gb_oam_scan.sv
// PPU mode-2 object scanner: walks OAM entries 0..39 and keeps up to 10 that overlap LY.
// Object word layout: [7:0]=y, [15:8]=x, [23:16]=tile, [31:24]=attr. Optional macro: OAM_SCAN_DMA_BLOCK_EN.
module gb_oam_scan (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_start,
    input  logic [7:0]  ly_i,
    input  logic        obj_size_i,
    input  logic        dma_active_i,
    input  logic [31:0] obj_i,
    output logic [6:0]  index_ppu_o,
    output logic        scan_active,
    output logic        scan_done,
    output logic [3:0]  buf_count_o,
    input  logic [3:0]  buf_rd_idx_i,
    output logic [31:0] buf_obj_o,
    output logic [5:0]  buf_oam_idx_o,
    output logic [3:0]  buf_row_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  obj_cnt_q, obj_cnt_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  ly_q, ly_d;
    logic        size_q, size_d;
    logic        done_q, done_d;
    logic        wr_en;

    logic [31:0] obj_buf_q [10];
    logic [5:0]  idx_buf_q [10];
    logic [3:0]  row_buf_q [10];

    logic [8:0]  ly_off, y_ext, d, h;
    logic        hit;
    logic [3:0]  rd_sel;

    assign ly_off = {1'b0, ly_q} + 9'd16;
    assign y_ext  = {1'b0, obj_i[7:0]};
    assign d      = ly_off - y_ext;
    assign h      = size_q ? 9'd16 : 9'd8;

`ifdef OAM_SCAN_DMA_BLOCK_EN
    // OAM reads return FFh while DMA owns the bus, so nothing can match.
    assign hit = (ly_off >= y_ext) && (d < h) && !dma_active_i;
`else
    logic unused_dma;
    assign unused_dma = dma_active_i;
    assign hit = (ly_off >= y_ext) && (d < h);
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        obj_cnt_d = obj_cnt_q;
        count_d   = count_q;
        ly_d      = ly_q;
        size_d    = size_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        if (scan_start) begin
            // A start pulse always (re)begins a scan, even mid-scan.
            ly_d      = ly_i;
            size_d    = obj_size_i;
            obj_cnt_d = 6'd0;
            count_d   = 4'd0;
            phase_d   = 1'b0;
            state_d   = SCAN;
        end else if (state_q == SCAN) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                if (hit && (count_q < 4'd10)) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 4'd1;
                end
                if (obj_cnt_q == 6'd39) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    obj_cnt_d = 6'd0;
                    phase_d   = 1'b0;
                end else begin
                    obj_cnt_d = obj_cnt_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            obj_cnt_q <= 6'd0;
            count_q   <= 4'd0;
            ly_q      <= 8'd0;
            size_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            obj_cnt_q <= obj_cnt_d;
            count_q   <= count_d;
            ly_q      <= ly_d;
            size_q    <= size_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 10; i++) begin
                obj_buf_q[i] <= 32'd0;
                idx_buf_q[i] <= 6'd0;
                row_buf_q[i] <= 4'd0;
            end
        end else if (wr_en) begin
            obj_buf_q[count_q] <= obj_i;
            idx_buf_q[count_q] <= obj_cnt_q;
            row_buf_q[count_q] <= d[3:0];
        end
    end

    assign rd_sel        = (buf_rd_idx_i > 4'd9) ? 4'd9 : buf_rd_idx_i;
    assign buf_obj_o     = obj_buf_q[rd_sel];
    assign buf_oam_idx_o = idx_buf_q[rd_sel];
    assign buf_row_o     = row_buf_q[rd_sel];

    assign index_ppu_o = (state_q == SCAN) ? {1'b0, obj_cnt_q} : 7'd0;
    assign scan_active = (state_q == SCAN);
    assign scan_done   = done_q;
    assign buf_count_o = count_q;

endmodule

// File: tb/tb_gb_oam_scan.sv
// Bench for gb_oam_scan: OAM model, table of boundary rows, scoreboard of expected slots.
module tb_gb_oam_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_start;
    logic [7:0]  ly_i;
    logic        obj_size_i;
    logic        dma_active_i;
    logic [31:0] obj_i;
    logic [6:0]  index_ppu_o;
    logic        scan_active;
    logic        scan_done;
    logic [3:0]  buf_count_o;
    logic [3:0]  buf_rd_idx_i;
    logic [31:0] buf_obj_o;
    logic [5:0]  buf_oam_idx_o;
    logic [3:0]  buf_row_o;

    logic [31:0] oam_mem [40];
    logic [9:0]  exp_q[$];   // {oam index, row}
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        logic [7:0] ly;
        logic       size;
        logic [7:0] y;
        logic       hit;
        logic [3:0] row;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    assign obj_i = (index_ppu_o < 7'd40) ? oam_mem[index_ppu_o[5:0]] : 32'hFFFF_FFFF;

    gb_oam_scan dut (
        .clk           (clk),
        .reset         (reset),
        .scan_start    (scan_start),
        .ly_i          (ly_i),
        .obj_size_i    (obj_size_i),
        .dma_active_i  (dma_active_i),
        .obj_i         (obj_i),
        .index_ppu_o   (index_ppu_o),
        .scan_active   (scan_active),
        .scan_done     (scan_done),
        .buf_count_o   (buf_count_o),
        .buf_rd_idx_i  (buf_rd_idx_i),
        .buf_obj_o     (buf_obj_o),
        .buf_oam_idx_o (buf_oam_idx_o),
        .buf_row_o     (buf_row_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic clear_oam();
        logic [23:0] r;
        for (int i = 0; i < 40; i++) begin
            r = 24'($urandom);
            oam_mem[i] = {r, 8'h00};
        end
    endtask

    task automatic start_scan(input logic [7:0] ly, input logic size);
        @(negedge clk);
        ly_i = ly;
        obj_size_i = size;
        scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
    endtask

    // Returns at the negedge inside the scan_done cycle.
    task automatic wait_done(input string name);
        int cycles = 0;
        int active = 0;
        logic idx_ok = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (scan_active) active++;
            if ((cycles % 2 == 1) && (cycles < 80) && (index_ppu_o != 7'((cycles - 1) / 2)))
                idx_ok = 1'b0;
        end while (!scan_done && cycles < 200);
        check({name, " done_latency"}, cycles, 81);
        check({name, " active_cycles"}, active, 80);
        check({name, " index_seq"}, {31'd0, idx_ok}, 1);
        check({name, " active_low_at_done"}, {31'd0, scan_active}, 0);
    endtask

    task automatic check_buffer(input string name);
        logic [9:0] e;
        int n;
        n = exp_q.size();
        check({name, " count"}, {28'd0, buf_count_o}, n);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            buf_rd_idx_i = 4'(i);
            #1;
            check({name, " slot_idx_row"}, {22'd0, buf_oam_idx_o, buf_row_o}, {22'd0, e});
            check({name, " slot_obj"}, buf_obj_o, oam_mem[e[9:4]]);
        end
        buf_rd_idx_i = 4'd0;
    endtask

    task automatic model_push(input logic [7:0] ly, input logic size);
        int d;
        int h;
        h = size ? 16 : 8;
        for (int i = 0; i < 40; i++) begin
            d = int'(ly) + 16 - int'(oam_mem[i][7:0]);
            if (d >= 0 && d < h && exp_q.size() < 10)
                exp_q.push_back({6'(i), 4'(d)});
        end
    endtask

    initial begin
        logic seen_done;
        logic [7:0] rly;
        logic       rsize;

        vecs[0] = '{ly: 8'd143, size: 1'b0, y: 8'd160, hit: 1'b0, row: 4'd0};
        vecs[1] = '{ly: 8'd143, size: 1'b0, y: 8'd159, hit: 1'b1, row: 4'd0};
        vecs[2] = '{ly: 8'd143, size: 1'b0, y: 8'd152, hit: 1'b1, row: 4'd7};
        vecs[3] = '{ly: 8'd143, size: 1'b0, y: 8'd151, hit: 1'b0, row: 4'd0};
        vecs[4] = '{ly: 8'd143, size: 1'b1, y: 8'd144, hit: 1'b1, row: 4'd15};
        vecs[5] = '{ly: 8'd143, size: 1'b1, y: 8'd143, hit: 1'b0, row: 4'd0};
        vecs[6] = '{ly: 8'd0,   size: 1'b1, y: 8'd1,   hit: 1'b1, row: 4'd15};
        vecs[7] = '{ly: 8'd0,   size: 1'b0, y: 8'd17,  hit: 1'b0, row: 4'd0};
        vecs[8] = '{ly: 8'd240, size: 1'b0, y: 8'd255, hit: 1'b1, row: 4'd1};

        reset = 1'b1;
        scan_start = 1'b0;
        ly_i = 8'd0;
        obj_size_i = 1'b0;
        dma_active_i = 1'b0;
        buf_rd_idx_i = 4'd0;
        clear_oam();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset scan_active", {31'd0, scan_active}, 0);
        check("reset scan_done", {31'd0, scan_done}, 0);
        check("reset count", {28'd0, buf_count_o}, 0);
        check("reset index", {25'd0, index_ppu_o}, 0);
        check("reset buf_obj", buf_obj_o, 0);

        // 8x8, ly=0: y=16 row 0, y=9 row 7, y=8 misses.
        clear_oam();
        oam_mem[0][7:0] = 8'd16;
        oam_mem[1][7:0] = 8'd9;
        oam_mem[2][7:0] = 8'd8;
        exp_q.push_back({6'd0, 4'd0});
        exp_q.push_back({6'd1, 4'd7});
        start_scan(8'd0, 1'b0);
        check("t1 active_after_start", {31'd0, scan_active}, 1);
        wait_done("t1");
        check_buffer("t1");

        // 8x16, ly=20, object 5 at y=21.
        clear_oam();
        oam_mem[5][7:0] = 8'd21;
        exp_q.push_back({6'd5, 4'd15});
        start_scan(8'd20, 1'b1);
        wait_done("t2");
        check_buffer("t2");

        // 12 hits: only the first 10 in OAM order survive; x is irrelevant.
        clear_oam();
        for (int i = 3; i <= 14; i++) begin
            oam_mem[i][7:0] = 8'd16;
            if (i < 13) exp_q.push_back({6'(i), 4'd0});
        end
        oam_mem[3][15:8] = 8'd0;
        oam_mem[4][15:8] = 8'd168;
        start_scan(8'd0, 1'b0);
        wait_done("t3");
        check_buffer("t3");
        buf_rd_idx_i = 4'd15;
        #1 check("t3 rd_clamp", {26'd0, buf_oam_idx_o}, 12);
        buf_rd_idx_i = 4'd0;

        // Boundary row table, object placed at the last OAM index.
        for (int v = 0; v < 9; v++) begin
            clear_oam();
            oam_mem[39][7:0] = vecs[v].y;
            if (vecs[v].hit) exp_q.push_back({6'd39, vecs[v].row});
            start_scan(vecs[v].ly, vecs[v].size);
            wait_done($sformatf("vec%0d", v));
            check_buffer($sformatf("vec%0d", v));
        end

        // Reset at cycle 30 of a scan.
        clear_oam();
        oam_mem[0][7:0] = 8'd16;
        start_scan(8'd0, 1'b0);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst active", {31'd0, scan_active}, 0);
        check("rst count", {28'd0, buf_count_o}, 0);
        seen_done = scan_done;
        repeat (100) begin
            @(negedge clk);
            seen_done = seen_done | scan_done;
        end
        check("rst no_done", {31'd0, seen_done}, 0);

        // Restart at cycle 40: done 80 cycles after the second start, count not doubled.
        clear_oam();
        oam_mem[0][7:0] = 8'd16;
        oam_mem[1][7:0] = 8'd9;
        exp_q.push_back({6'd0, 4'd0});
        exp_q.push_back({6'd1, 4'd7});
        start_scan(8'd0, 1'b0);
        repeat (39) @(negedge clk);
        start_scan(8'd0, 1'b0);
        wait_done("restart");
        check_buffer("restart");

        // DMA held for the whole scan with 4 overlapping objects.
        clear_oam();
        for (int i = 10; i < 14; i++) oam_mem[i][7:0] = 8'd16;
`ifndef OAM_SCAN_DMA_BLOCK_EN
        for (int i = 10; i < 14; i++) exp_q.push_back({6'(i), 4'd0});
`endif
        dma_active_i = 1'b1;
        start_scan(8'd0, 1'b0);
        wait_done("dma");
        dma_active_i = 1'b0;
        check_buffer("dma");

        // Random populations checked against a reference model.
        for (int r = 0; r < 3; r++) begin
            clear_oam();
            rly = 8'($urandom_range(0, 143));
            rsize = 1'($urandom_range(0, 1));
            for (int i = 0; i < 40; i++)
                oam_mem[i][7:0] = 8'(int'(rly) + 16 - int'($urandom_range(0, 40)));
            model_push(rly, rsize);
            start_scan(rly, rsize);
            wait_done($sformatf("rand%0d", r));
            check_buffer($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gb_oam_scan.md
# gb_oam_scan

PPU mode-2 object scanner. It sits directly downstream of the OAM/DMA block. The scanner walks all 40 OAM objects through the OAM index/object port and selects, in OAM order, up to 10 objects that overlap the current scanline. It stores them in an internal line buffer, which the object fetcher reads during mode 3.

## Interface
No parameters.
- clk  in  1  PPU dot clock (4 dots per M-cycle)
- reset  in  1  synchronous, active-high reset
- scan_start  in  1  one-cycle pulse at the start of mode 2
- ly_i  in  8  current scanline (LY), sampled on scan_start
- obj_size_i  in  1  LCDC.2; 0 = 8x8, 1 = 8x16; sampled on scan_start
- dma_active_i  in  1  OAM DMA in progress (used only with the configuration macro)
- obj_i  in  oam_obj_t  object at index_ppu_o, combinational from OAM
- index_ppu_o  out  7  OAM object index driven to OAM (0..39)
- scan_active  out  1  scan in progress
- scan_done  out  1  one-cycle pulse when the scan completes
- buf_count_o  out  4  number of selected objects (0..10)
- buf_rd_idx_i  in  4  line-buffer read slot (0..9)
- buf_obj_o  out  oam_obj_t  stored object at buf_rd_idx_i (combinational read)
- buf_oam_idx_o  out  6  OAM index of the stored object
- buf_row_o  out  4  unflipped row within the object: ly+16-y

## Operation
- States: IDLE, SCAN. A phase bit toggles each cycle in SCAN, and obj_cnt (6 bits, 0..39) counts objects.
- IDLE, scan_start=1:
  - latch ly_i and obj_size_i
  - clear buf_count_o and obj_cnt; phase=0
  - enter SCAN
- SCAN phase 0: index_ppu_o = obj_cnt so OAM can settle.
- SCAN phase 1: evaluate obj_i.
  - Compute in 9 bits: h = 8 or 16; d = {1'b0,ly}+16-{1'b0,y}.
  - Hit when {1'b0,ly}+16 >= y and d < h. Hits are independent of x; objects with x=0 or x>=168 still count.
  - On a hit with buf_count_o<10: write the slot at buf_count_o with {obj_i, obj_cnt, d[3:0]}, then increment buf_count_o.
  - A hit with buf_count_o==10 is dropped silently.
  - Then obj_cnt++. If obj_cnt was 39, go to IDLE and pulse scan_done.
- scan_start during SCAN restarts the scan: relatch inputs, clear the count, set obj_cnt=0 and phase=0.
- In IDLE, index_ppu_o = 0. The buffer and buf_count_o hold their values until the next scan_start.
- Slots at or above buf_count_o hold stale data. Reads there are don't-care.
- buf_rd_idx_i > 9 returns slot 9.

## Timing
- Reset values:
  - state IDLE; scan_active=0; scan_done=0
  - buf_count_o=0; index_ppu_o=0; obj_cnt=0; phase=0
  - buffer contents cleared to 0
- Let E0 be the clk edge that samples scan_start=1.
  - scan_active goes high after E0.
  - Object k is presented during cycles 2k+1 and 2k+2 after E0, and written at edge E(2k+2).
  - The last object is written at E80. scan_active drops after E80 and is high for exactly 80 cycles.
  - scan_done is high for the single cycle after E80. buf_count_o is final when scan_done is high.
- Reset asserted mid-scan: return to IDLE on the next edge with count 0 and no scan_done.
- The buffer read path is combinational, with zero latency.

## Configuration
- OAM_SCAN_DMA_BLOCK_EN defined: an evaluation cycle with dma_active_i=1 never hits, matching hardware behaviour where OAM reads return FFh during DMA. obj_cnt still advances and timing is unchanged.
- Macro undefined: dma_active_i is ignored and evaluation uses obj_i as-is.

## Test plan
- 8x8 mode, ly=0; objects 0..2 with y=16, 9, 8; others y=0.
  - Required: scan_done one cycle after E80; count=2; slot0 = oam 0 with row 0; slot1 = oam 1 with row 7.
- 8x16 mode, ly=20, object 5 with y=21 (d=15).
  - Required: count=1; buf_row_o=15; buf_oam_idx_o=5.
- 12 objects with y=16 at indices 3..14, ly=0.
  - Required: count=10; slots hold indices 3..12 in order; indices 13 and 14 are dropped.
- Check boundary rows:
  - ly=143 with y=160 in 8x8: d=-1, miss.
  - ly=143 with y=159: row 0, hit.
  - ly=143 with y=152: row 7, hit.
- Abort and restart paths:
  - Reset at cycle 30 of a scan: scan_active low next cycle, count=0, no scan_done.
  - A second scan_start at cycle 40: scan_done comes 80 cycles after the restart.
- DMA blocking: hold dma_active_i=1 for a whole scan with 4 overlapping objects.
  - With OAM_SCAN_DMA_BLOCK_EN: count=0.
  - Without it: count=4.
